// File: rtl/sc_muldiv.sv
// sc_muldiv: iterative RV32M multiply/divide unit.
// Multiplication uses one shift-add step per cycle. Division uses one restoring step per cycle.
// Latency is fixed at XLEN+1 cycles from the accepting edge, whatever the operand values.
module sc_muldiv #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    // Iteration counter width, derived from XLEN so that it can hold the value XLEN.
    localparam int unsigned CW = $clog2(XLEN + 1);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2:0]          op_q, op_d;
    logic [XLEN-1:0]     opnd_q, opnd_d;          // multiplicand or divisor magnitude
    logic [2*XLEN-1:0]   acc_q, acc_d;            // {product hi, lo} or {remainder, quotient}
    logic                neg_q, neg_d;            // negate the selected result in FIN
    logic                spec_q, spec_d;          // divide-by-zero or signed overflow
    logic [XLEN-1:0]     spec_val_q, spec_val_d;  // value forced in FIN for special cases
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [XLEN-1:0]     result_q, result_d;

    // Values that are decoded from the live operands when a start is accepted.
    logic                is_div, a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0]     a_mag, b_mag;

    // Values produced by one iteration step and by the final result fix-up.
    logic [XLEN-1:0]     mul_addend, rem_neg, fin_val;
    logic [XLEN:0]       mul_sum, div_shift, div_diff;
    logic                div_borrow;
    logic [2*XLEN-1:0]   acc_step, acc_neg;

    // Start-time decode: operand signedness, magnitudes and special-case detection.
    always_comb begin
        is_div   = op[2];
        a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
        b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        a_neg    = a_signed && a[XLEN-1];
        b_neg    = b_signed && b[XLEN-1];
        a_mag    = a_neg ? ('0 - a) : a;
        b_mag    = b_neg ? ('0 - b) : b;
        div_zero = is_div && (b == '0);
        div_ovf  = ((op == OP_DIV) || (op == OP_REM)) && (a == MIN_NEG) && (b == '1);
    end

    // One shift-add or restoring-divide step, plus the sign fix and result select used in FIN.
    always_comb begin
        mul_addend = acc_q[0] ? opnd_q : '0;
        mul_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mul_addend};
        div_shift  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff   = div_shift - {1'b0, opnd_q};
        div_borrow = div_diff[XLEN];
        if (op_q[2]) begin
            acc_step = {(div_borrow ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0]),
                        acc_q[XLEN-2:0], ~div_borrow};
        end else begin
            acc_step = {mul_sum, acc_q[XLEN-1:1]};
        end

        // Negating the full register also negates the low half (the quotient) on its own.
        acc_neg = '0 - acc_q;
        rem_neg = '0 - acc_q[2*XLEN-1:XLEN];
        case (op_q)
            OP_MUL, OP_DIV, OP_DIVU:
                fin_val = neg_q ? acc_neg[XLEN-1:0] : acc_q[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:
                fin_val = neg_q ? acc_neg[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
            default:
                fin_val = neg_q ? rem_neg : acc_q[2*XLEN-1:XLEN];
        endcase
        if (spec_q) begin
            fin_val = spec_val_q;
        end
    end

    // Next-state and datapath update for the IDLE -> RUN -> FIN sequence.
    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case infers a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        opnd_d     = opnd_q;
        acc_d      = acc_q;
        neg_d      = neg_q;
        spec_d     = spec_q;
        spec_val_d = spec_val_q;
        result_d   = result_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    state_d = RUN;
                    cnt_d   = CW'(XLEN);
                    op_d    = op;
                    opnd_d  = is_div ? b_mag : a_mag;
                    acc_d   = {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
                    // For REM and REMU the result takes the sign of the dividend.
                    neg_d   = (is_div && op[1]) ? a_neg : (a_neg ^ b_neg);
                    spec_d  = div_zero || div_ovf;
                    if (div_zero) begin
                        spec_val_d = op[1] ? a : '1;
                    end else begin
                        spec_val_d = op[1] ? '0 : MIN_NEG;
                    end
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d = acc_step;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = FIN;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
                if (!flush) begin
                    result_d = fin_val;
                    done_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
    end

    // State and datapath registers. An asynchronous reset clears all of them.
    always_ff @(posedge clock or negedge resetn) begin
        // NOTE: the datapath registers are reset as well as the control registers, so that no stale value survives a reset.
        if (!resetn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            opnd_q     <= '0;
            acc_q      <= '0;
            neg_q      <= 1'b0;
            spec_q     <= 1'b0;
            spec_val_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register update from values sampled before the edge.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            opnd_q     <= opnd_d;
            acc_q      <= acc_d;
            neg_q      <= neg_d;
            spec_q     <= spec_d;
            spec_val_q <= spec_val_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_sc_muldiv.sv
// tb_sc_muldiv: directed scoreboard bench for sc_muldiv at XLEN = 32 and XLEN = 8.
module tb_sc_muldiv;
    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    logic        clock = 1'b0;
    logic        resetn;
    logic        start32, start8, flush;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy32, done32, busy8, done8;
    logic [31:0] result32;
    logic [7:0]  result8;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last32 = '0;

    always #5 clock = ~clock;

    sc_muldiv #(.XLEN(32)) dut32 (
        .clock(clock), .resetn(resetn), .start(start32), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy32), .done(done32), .result(result32)
    );

    sc_muldiv #(.XLEN(8)) dut8 (
        .clock(clock), .resetn(resetn), .start(start8), .op(op), .a(a[7:0]), .b(b[7:0]),
        .flush(flush), .busy(busy8), .done(done8), .result(result8)
    );

    // Reference model of the RV32M semantics at width n (n <= 32), using native 64-bit arithmetic.
    function automatic logic [31:0] model(input int n, input logic [2:0] o,
                                          input logic [31:0] x, input logic [31:0] y);
        longint mask, ua, ub, sa, sb, r;
        mask = (longint'(1) <<< n) - 1;
        ua   = longint'(x) & mask;
        ub   = longint'(y) & mask;
        sa   = ua[n-1] ? ua - (longint'(1) <<< n) : ua;
        sb   = ub[n-1] ? ub - (longint'(1) <<< n) : ub;
        r    = 0;
        case (o)
            OP_MUL:    r = sa * sb;
            OP_MULH:   r = (sa * sb) >>> n;
            OP_MULHSU: r = (sa * ub) >>> n;
            OP_MULHU:  r = (ua * ub) >>> n;
            OP_DIV: begin
                if (sb == 0) r = mask;
                else if (sa == -(longint'(1) <<< (n - 1)) && sb == -1) r = sa;
                else r = sa / sb;
            end
            OP_REM: begin
                if (sb == 0) r = ua;
                else if (sa == -(longint'(1) <<< (n - 1)) && sb == -1) r = 0;
                else r = sa % sb;
            end
            OP_DIVU: begin
                if (ub == 0) r = mask;
                else r = ua / ub;
            end
            default: begin
                if (ub == 0) r = ua;
                else r = ua % ub;
            end
        endcase
        return 32'(r & mask);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // The caller is at a negedge. The task drives a start pulse across the next posedge.
    task automatic start_op(input bit s8, input logic [2:0] o, input logic [31:0] x,
                            input logic [31:0] y, input bit push);
        if (push) exp_q.push_back(model(s8 ? 8 : 32, o, x, y));
        op = o;
        a  = x;
        b  = y;
        if (s8) start8 = 1'b1;
        else    start32 = 1'b1;
        @(negedge clock);
        start8  = 1'b0;
        start32 = 1'b0;
    endtask

    // Bounded wait for done. The task checks the latency, the busy length and the result against the scoreboard.
    task automatic wait_done(input bit s8, input string tag, input int e0);
        int          e, busy_cnt, xl;
        logic [31:0] exp, got;
        xl       = s8 ? 8 : 32;
        e        = e0;
        busy_cnt = e0;
        while (!(s8 ? done8 : done32) && e < 200) begin
            if (s8 ? busy8 : busy32) busy_cnt++;
            @(negedge clock);
            e++;
        end
        check({tag, " latency"}, 32'(e), 32'(xl + 1));
        check({tag, " busy cycles"}, 32'(busy_cnt), 32'(xl));
        got = s8 ? {24'h0, result8} : result32;
        exp = 32'hDEAD_BEEF;
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        check({tag, " result"}, got, exp);
        if (!s8) last32 = exp;
    endtask

    task automatic do_op(input bit s8, input string tag, input logic [2:0] o,
                         input logic [31:0] x, input logic [31:0] y);
        start_op(s8, o, x, y, 1'b1);
        wait_done(s8, tag, 0);
    endtask

    task automatic count_done(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            if (done32) n++;
            @(negedge clock);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n_done;
        logic [31:0] prev;
        resetn  = 1'b0;
        start32 = 1'b0;
        start8  = 1'b0;
        flush   = 1'b0;
        op      = '0;
        a       = '0;
        b       = '0;
        repeat (2) @(negedge clock);
        check("reset busy32", {31'h0, busy32}, 32'h0);
        check("reset done32", {31'h0, done32}, 32'h0);
        check("reset result32", result32, 32'h0);
        check("reset result8", {24'h0, result8}, 32'h0);
        resetn = 1'b1;
        @(negedge clock);

        // Multiply scenarios. These ops run back-to-back: each start is issued in the done cycle of the op before it.
        do_op(0, "MUL ffxff", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op(0, "MULHU ffxff", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op(0, "MULH -2x3", OP_MULH, 32'hFFFF_FFFE, 32'h0000_0003);
        do_op(0, "MULHSU -2x3", OP_MULHSU, 32'hFFFF_FFFE, 32'h0000_0003);
        do_op(0, "MULHSU -2x8000", OP_MULHSU, 32'hFFFF_FFFE, 32'h8000_0000);
        do_op(0, "MULH -2x8000", OP_MULH, 32'hFFFF_FFFE, 32'h8000_0000);
        @(negedge clock);
        check("done single pulse", {31'h0, done32}, 32'h0);

        // Divide scenarios and corner cases.
        do_op(0, "DIV -7/2", OP_DIV, 32'hFFFF_FFF9, 32'h2);
        do_op(0, "REM -7/2", OP_REM, 32'hFFFF_FFF9, 32'h2);
        do_op(0, "DIVU -7/2", OP_DIVU, 32'hFFFF_FFF9, 32'h2);
        do_op(0, "REMU -7/2", OP_REMU, 32'hFFFF_FFF9, 32'h2);
        do_op(0, "DIV by 0", OP_DIV, 32'h1234_5678, 32'h0);
        do_op(0, "REM by 0", OP_REM, 32'h1234_5678, 32'h0);
        do_op(0, "DIVU by 0", OP_DIVU, 32'h1234_5678, 32'h0);
        do_op(0, "REMU by 0", OP_REMU, 32'hF234_5678, 32'h0);
        do_op(0, "REM -a by 0", OP_REM, 32'hF234_5678, 32'h0);
        do_op(0, "DIV ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op(0, "REM ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op(0, "REM neg/neg", OP_REM, 32'hFFFF_FF9C, 32'hFFFF_FFF9);
        for (int i = 0; i < 6; i++) begin
            do_op(0, "random", 3'($urandom_range(0, 7)), $urandom, $urandom_range(0, 3) == 0 ? 32'($urandom_range(1, 9)) : $urandom);
        end

        // A second start in the middle of a run is ignored.
        start_op(0, OP_DIV, 32'hFFFF_FFF9, 32'h2, 1'b1);
        repeat (9) @(negedge clock);
        op      = OP_MUL;
        a       = 32'h1234;
        b       = 32'h5678;
        start32 = 1'b1;
        @(negedge clock);
        start32 = 1'b0;
        wait_done(0, "start ignored", 10);

        // A flush at cycle 5 aborts the run: no done, and the result is held.
        prev = last32;
        start_op(0, OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        repeat (4) @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        count_done(40, n_done);
        check("flush no done", 32'(n_done), 32'h0);
        check("flush result held", result32, prev);
        check("flush busy low", {31'h0, busy32}, 32'h0);

        // A flush in IDLE blocks a coincident start.
        flush = 1'b1;
        start_op(0, OP_MUL, 32'h2, 32'h3, 1'b0);
        flush = 1'b0;
        check("flush blocks start", {31'h0, busy32}, 32'h0);
        count_done(40, n_done);
        check("blocked start no done", 32'(n_done), 32'h0);

        // An asynchronous reset in the middle of a run clears the outputs immediately.
        start_op(0, OP_DIVU, 32'h1234_5678, 32'h3, 1'b0);
        repeat (14) @(negedge clock);
        #2 resetn = 1'b0;
        #1;
        check("async reset busy", {31'h0, busy32}, 32'h0);
        check("async reset done", {31'h0, done32}, 32'h0);
        check("async reset result", result32, 32'h0);
        @(negedge clock);
        resetn = 1'b1;
        count_done(40, n_done);
        check("aborted op no done", 32'(n_done), 32'h0);
        do_op(0, "MUL 3x5 after reset", OP_MUL, 32'h3, 32'h5);

        // Narrow instance: XLEN = 8.
        do_op(1, "x8 MULHU ffxff", OP_MULHU, 32'hFF, 32'hFF);
        do_op(1, "x8 MUL ffxff", OP_MUL, 32'hFF, 32'hFF);
        do_op(1, "x8 MULH -2x3", OP_MULH, 32'hFE, 32'h03);
        do_op(1, "x8 MULHSU -2x80", OP_MULHSU, 32'hFE, 32'h80);
        do_op(1, "x8 MULH -2x80", OP_MULH, 32'hFE, 32'h80);
        do_op(1, "x8 DIV -7/2", OP_DIV, 32'hF9, 32'h02);
        do_op(1, "x8 DIV ovf", OP_DIV, 32'h80, 32'hFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
